// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_tgt_pkg;

    localparam int   BIT_CNT_W = 3;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IDLE_WAIT
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the asynchronous SCL/SDA pads and derives single-cycle
// bus events (SCL edges, START, STOP) in the clk domain.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_q;
    logic                   sda_q;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Synchroniser chains plus one edge-detect stage; reset to an idle (high) bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    // START/STOP require SCL high on both sides of the SDA transition.
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing register pointer into a small
// register bank, plus a host-side port for preloading and observation.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for START
// ADDR      | shifting in the 7-bit address and R/W bit
// ADDR_ACK  | driving ACK for a matching address
// PTR       | shifting in the register pointer byte
// PTR_ACK   | driving ACK for the pointer byte
// WR_DATA   | shifting in a data byte for regs[pointer]
// WR_ACK    | driving ACK; the register is written as the ACK ends
// RD_DATA   | shifting regs[pointer] out, MSB first
// RD_ACK    | sampling the controller's ACK/NACK
// IDLE_WAIT | read NACK'd; SDA released until START or STOP
module i2c_target_regfile
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         REG_DEPTH   = 16,
    parameter int         REG_AW      = $clog2(REG_DEPTH),
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic              host_wr_en,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [7:0]        host_wr_data,
    output logic [7:0]        host_rd_data,
    output logic              rx_valid,
    output logic [REG_AW-1:0] rx_addr,
    output logic [7:0]        rx_data,
    output logic              busy
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    state_t                state;
    state_t                state_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt_nxt;
    logic [7:0]            shift;
    logic [7:0]            shift_nxt;
    logic [REG_AW-1:0]     pointer;
    logic [REG_AW-1:0]     pointer_nxt;
    logic                  rw;
    logic                  rw_nxt;
    logic                  ack_on;
    logic                  ack_on_nxt;
    logic                  reload;
    logic                  reload_nxt;
    logic                  sda_oe_nxt;
    logic                  busy_nxt;
    logic                  i2c_wr;

    logic [7:0]            regs [REG_DEPTH];
    logic [7:0]            rd_byte;
    logic [7:0]            shift_in;
    logic                  last_bit;

    assign rd_byte      = regs[pointer];
    assign shift_in     = {shift[6:0], sda_s};
    assign last_bit     = (bit_cnt == '1);
    assign host_rd_data = regs[host_addr];

    // Next-state and datapath decode; START/STOP override every state.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        pointer_nxt = pointer;
        rw_nxt      = rw;
        ack_on_nxt  = ack_on;
        reload_nxt  = reload;
        sda_oe_nxt  = sda_oe;
        busy_nxt    = busy;
        i2c_wr      = 1'b0;

        if (stop) begin
            state_nxt  = IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            reload_nxt = 1'b0;
            ack_on_nxt = 1'b0;
        end else if (start) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            reload_nxt  = 1'b0;
            ack_on_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE, IDLE_WAIT: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = shift_in;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (last_bit) begin
                            if (shift_in[7:1] == DEV_ADDR) begin
                                rw_nxt     = shift_in[0];
                                ack_on_nxt = 1'b0;
                                busy_nxt   = 1'b1;
                                state_nxt  = ADDR_ACK;
                            end else begin
                                busy_nxt  = 1'b0;
                                state_nxt = IDLE;
                            end
                        end
                    end
                end

                // First fall starts the ACK; second fall ends it. For a read
                // the first data bit goes out on that same ending fall.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe_nxt = 1'b1;
                            ack_on_nxt = 1'b1;
                        end else begin
                            ack_on_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            if (rw) begin
                                shift_nxt  = rd_byte;
                                sda_oe_nxt = ~rd_byte[7];
                                state_nxt  = RD_DATA;
                            end else begin
                                sda_oe_nxt = 1'b0;
                                state_nxt  = PTR;
                            end
                        end
                    end
                end

                PTR: begin
                    if (scl_rise) begin
                        shift_nxt   = shift_in;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (last_bit) begin
                            pointer_nxt = shift_in[REG_AW-1:0];
                            ack_on_nxt  = 1'b0;
                            state_nxt   = PTR_ACK;
                        end
                    end
                end

                PTR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe_nxt = 1'b1;
                            ack_on_nxt = 1'b1;
                        end else begin
                            ack_on_nxt  = 1'b0;
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = WR_DATA;
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt   = shift_in;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (last_bit) begin
                            ack_on_nxt = 1'b0;
                            state_nxt  = WR_ACK;
                        end
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe_nxt = 1'b1;
                            ack_on_nxt = 1'b1;
                        end else begin
                            ack_on_nxt  = 1'b0;
                            sda_oe_nxt  = 1'b0;
                            i2c_wr      = 1'b1;
                            pointer_nxt = pointer + 1'b1;
                            bit_cnt_nxt = '0;
                            state_nxt   = WR_DATA;
                        end
                    end
                end

                // After an ACK'd byte the next byte is fetched on the fall that
                // ends the ACK bit, so it reflects the incremented pointer.
                RD_DATA: begin
                    if (scl_fall) begin
                        if (reload) begin
                            shift_nxt   = rd_byte;
                            sda_oe_nxt  = ~rd_byte[7];
                            bit_cnt_nxt = '0;
                            reload_nxt  = 1'b0;
                        end else if (last_bit) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = RD_ACK;
                        end else begin
                            shift_nxt   = {shift[6:0], 1'b0};
                            sda_oe_nxt  = ~shift[6];
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        pointer_nxt = pointer + 1'b1;
                        if (sda_s == ACK) begin
                            reload_nxt = 1'b1;
                            state_nxt  = RD_DATA;
                        end else begin
                            state_nxt = IDLE_WAIT;
                        end
                    end
                end

                default: begin
                    state_nxt  = IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // State register, datapath registers and the registered rx strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            pointer  <= '0;
            rw       <= 1'b0;
            ack_on   <= 1'b0;
            reload   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_addr  <= '0;
            rx_data  <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            pointer  <= pointer_nxt;
            rw       <= rw_nxt;
            ack_on   <= ack_on_nxt;
            reload   <= reload_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            rx_valid <= i2c_wr;
            if (i2c_wr) begin
                rx_addr <= pointer;
                rx_data <= shift;
            end
        end
    end

    // Register bank; a bus write to the same address as a host write wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (host_wr_en && !(i2c_wr && (host_addr == pointer))) begin
                regs[host_addr] <= host_wr_data;
            end
            if (i2c_wr) begin
                regs[pointer] <= shift;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-level I2C controller drives the bus
// while a transaction-level register/pointer model predicts every result.
module tb_i2c_target_regfile;

    localparam int         SYNC_STAGES = 2;
    localparam int         REG_DEPTH   = 16;
    localparam int         REG_AW      = 4;
    localparam logic [6:0] DEV         = 7'h50;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              scl_m;
    logic              m_low;
    logic              sda_line;
    logic              sda_oe;
    logic              host_wr_en;
    logic [REG_AW-1:0] host_addr;
    logic [7:0]        host_wr_data;
    logic [7:0]        host_rd_data;
    logic              rx_valid;
    logic [REG_AW-1:0] rx_addr;
    logic [7:0]        rx_data;
    logic              busy;

    always #5 clk = ~clk;

    // Open-drain bus: either side may pull SDA low.
    assign sda_line = ~(m_low | sda_oe);

    i2c_target_regfile #(
        .DEV_ADDR    (DEV),
        .REG_DEPTH   (REG_DEPTH),
        .REG_AW      (REG_AW),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (scl_m),
        .sda_i        (sda_line),
        .sda_oe       (sda_oe),
        .host_wr_en   (host_wr_en),
        .host_addr    (host_addr),
        .host_wr_data (host_wr_data),
        .host_rd_data (host_rd_data),
        .rx_valid     (rx_valid),
        .rx_addr      (rx_addr),
        .rx_data      (rx_data),
        .busy         (busy)
    );

    int          tests = 0;
    int          fails = 0;
    int          half  = 10;
    int          q     = 5;
    logic [7:0]  model_regs [REG_DEPTH];
    int          model_ptr;
    logic [11:0] exp_q [$];
    logic [11:0] e_item;
    logic        no_drive;
    logic        col_en;
    logic [3:0]  col_addr;
    logic [7:0]  col_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare: rx strobes against the expected-write queue,
    // and SDA must stay released whenever the target has no business driving.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rx_spurious", 32'(rx_valid), 32'd0);
            end else if (rx_valid === 1'b1) begin
                e_item = exp_q.pop_front();
                check("rx_addr", 32'(rx_addr), 32'(e_item[11:8]));
                check("rx_data", 32'(rx_data), 32'(e_item[7:0]));
            end
            if (no_drive) check("sda_quiet", 32'(sda_oe), 32'd0);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (scl_m == 1'b0) begin
            m_low = 1'b0; clks(q);
            scl_m = 1'b1; clks(half);
        end
        m_low = 1'b1; clks(half);
        scl_m = 1'b0; clks(q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; clks(q);
        scl_m = 1'b1; clks(half);
        m_low = 1'b0; clks(half);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b;   clks(q);
        scl_m = 1'b1; clks(half);
        scl_m = 1'b0; clks(q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 1'b0; clks(q);
        scl_m = 1'b1; clks(half / 2);
        ack = sda_line;
        clks(half - half / 2);
        scl_m = 1'b0;
        if (col_en) begin
            // Host write lands in the same clk as the bus write of this byte.
            clks(SYNC_STAGES);
            host_addr    = col_addr;
            host_wr_data = col_data;
            host_wr_en   = 1'b1;
            clks(1);
            host_wr_en   = 1'b0;
            check("collide_align", 32'(rx_valid), 32'd1);
            col_en = 1'b0;
            clks(q - SYNC_STAGES - 1);
        end else begin
            clks(q);
        end
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            clks(q);
            scl_m = 1'b1; clks(half / 2);
            b[i] = sda_line;
            clks(half - half / 2);
            scl_m = 1'b0; clks(q);
        end
        send_bit(nack);
    endtask

    task automatic t_addr(input logic rw);
        logic ack;
        write_byte({DEV, rw}, ack);
        check("addr_ack", 32'(ack), 32'd0);
        check("busy_set", 32'(busy), 32'd1);
    endtask

    task automatic t_ptr(input logic [7:0] p);
        logic ack;
        write_byte(p, ack);
        check("ptr_ack", 32'(ack), 32'd0);
        model_ptr = int'(p[3:0]);
    endtask

    task automatic t_wdata(input logic [7:0] d);
        logic       ack;
        logic [3:0] wp;
        wp = 4'(model_ptr);
        exp_q.push_back({wp, d});
        model_regs[wp] = d;
        if (col_en && col_addr != wp) model_regs[col_addr] = col_data;
        model_ptr = (model_ptr + 1) % REG_DEPTH;
        write_byte(d, ack);
        check("data_ack", 32'(ack), 32'd0);
    endtask

    task automatic t_rdata(input logic nack, output logic [7:0] got);
        logic [7:0] exp;
        exp = model_regs[model_ptr];
        model_ptr = (model_ptr + 1) % REG_DEPTH;
        read_byte(nack, got);
        check("rd_data", 32'(got), 32'(exp));
    endtask

    task automatic t_end();
        bus_stop();
        check("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr    = a;
        host_wr_data = d;
        host_wr_en   = 1'b1;
        clks(1);
        host_wr_en   = 1'b0;
        model_regs[a] = d;
    endtask

    task automatic host_peek(input logic [3:0] a, output logic [7:0] v);
        host_addr = a;
        #1;
        v = host_rd_data;
    endtask

    task automatic check_regs();
        logic [7:0] v;
        for (int i = 0; i < REG_DEPTH; i++) begin
            host_peek(4'(i), v);
            check($sformatf("reg[%0d]", i), 32'(v), 32'(model_regs[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_DEPTH; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] got;
        logic       ack;
        logic [6:0] bad;
        int         kind;
        int         n;

        rst_n = 1'b0; scl_m = 1'b1; m_low = 1'b0;
        host_wr_en = 1'b0; host_addr = '0; host_wr_data = '0;
        no_drive = 1'b0; col_en = 1'b0; col_addr = '0; col_data = '0;
        model_reset();
        clks(5);
        check("rst_sda_oe",   32'(sda_oe),   32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_addr",  32'(rx_addr),  32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        rst_n = 1'b1;
        clks(4);
        check_regs();

        // Write pointer 0x0A then two data bytes.
        bus_start(); t_addr(1'b0); t_ptr(8'h0A); t_wdata(8'h12); t_wdata(8'h34); t_end();
        host_peek(4'hA, got); check("t1_regA", 32'(got), 32'h12);
        host_peek(4'hB, got); check("t1_regB", 32'(got), 32'h34);
        host_write(4'hC, 8'h5C);
        bus_start(); t_addr(1'b1); t_rdata(1'b1, got); t_end();
        check("t1_ptrC", 32'(got), 32'h5C);

        // Host preload then pointer write, Sr, 4-byte read.
        host_write(4'd4, 8'hDE); host_write(4'd5, 8'hAD);
        host_write(4'd6, 8'hBE); host_write(4'd7, 8'hEF);
        host_write(4'd8, 8'h88);
        bus_start(); t_addr(1'b0); t_ptr(8'h04);
        bus_start(); t_addr(1'b1);
        t_rdata(1'b0, got); check("t2_b0", 32'(got), 32'hDE);
        t_rdata(1'b0, got); check("t2_b1", 32'(got), 32'hAD);
        t_rdata(1'b0, got); check("t2_b2", 32'(got), 32'hBE);
        t_rdata(1'b1, got); check("t2_b3", 32'(got), 32'hEF);
        check("t2_release", 32'(sda_oe), 32'd0);
        check("t2_busy_held", 32'(busy), 32'd1);
        t_end();
        bus_start(); t_addr(1'b1); t_rdata(1'b1, got); t_end();
        check("t2_ptr8", 32'(got), 32'h88);

        // Foreign address: no ACK, no drive, no writes.
        no_drive = 1'b1;
        bus_start();
        write_byte(8'hA2, ack); check("t3_addr_nack", 32'(ack), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        write_byte(8'h00, ack); check("t3_ptr_nack", 32'(ack), 32'd1);
        write_byte(8'h55, ack); check("t3_data_nack", 32'(ack), 32'd1);
        bus_stop();
        no_drive = 1'b0;
        check("t3_busy_end", 32'(busy), 32'd0);

        // Pointer wrap from 15 to 0, then bare read from 1.
        bus_start(); t_addr(1'b0); t_ptr(8'h0F); t_wdata(8'h55); t_wdata(8'h66); t_end();
        host_peek(4'hF, got); check("t4_reg15", 32'(got), 32'h55);
        host_peek(4'h0, got); check("t4_reg0",  32'(got), 32'h66);
        host_write(4'd1, 8'hC3);
        bus_start(); t_addr(1'b1); t_rdata(1'b1, got); t_end();
        check("t4_read1", 32'(got), 32'hC3);

        // Same-cycle host writes: same address drops, different address lands.
        bus_start(); t_addr(1'b0); t_ptr(8'h03);
        col_en = 1'b1; col_addr = 4'd3; col_data = 8'h99; t_wdata(8'h77);
        col_en = 1'b1; col_addr = 4'd9; col_data = 8'h42; t_wdata(8'h31);
        t_end();
        host_peek(4'd3, got); check("t5_reg3", 32'(got), 32'h77);
        host_peek(4'd4, got); check("t5_reg4", 32'(got), 32'h31);
        host_peek(4'd9, got); check("t5_reg9", 32'(got), 32'h42);

        // Reset while the target drives a zero bit of a read.
        host_write(4'd2, 8'h00);
        bus_start(); t_addr(1'b0); t_ptr(8'h02);
        bus_start(); t_addr(1'b1);
        m_low = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clks(q); scl_m = 1'b1; clks(half); scl_m = 1'b0; clks(q);
        end
        check("t6_driving", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        clks(1);
        check("t6_rst_release", 32'(sda_oe), 32'd0);
        clks(3);
        rst_n = 1'b1;
        model_reset();
        no_drive = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clks(q); scl_m = 1'b1; clks(half); scl_m = 1'b0; clks(q);
        end
        bus_stop();
        no_drive = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check_regs();
        bus_start(); t_addr(1'b0); t_ptr(8'h00); t_wdata(8'h5A); t_end();
        host_peek(4'd0, got); check("t6_reg0", 32'(got), 32'h5A);

        // Randomised mix of transactions at varying SCL rates.
        for (int it = 0; it < 25; it++) begin
            half = int'($urandom_range(10, 14));
            q    = half / 2;
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: begin
                    bus_start(); t_addr(1'b0); t_ptr(8'($urandom));
                    n = int'($urandom_range(0, 3));
                    for (int k = 0; k < n; k++) t_wdata(8'($urandom));
                    t_end();
                end
                1: begin
                    bus_start(); t_addr(1'b0); t_ptr(8'($urandom));
                    if ($urandom_range(0, 1) == 1) t_wdata(8'($urandom));
                    bus_start(); t_addr(1'b1);
                    n = int'($urandom_range(1, 3));
                    for (int k = 0; k < n; k++) t_rdata(k == n - 1, got);
                    t_end();
                end
                2: begin
                    bus_start(); t_addr(1'b1);
                    n = int'($urandom_range(1, 3));
                    for (int k = 0; k < n; k++) t_rdata(k == n - 1, got);
                    t_end();
                end
                3: begin
                    n = int'($urandom_range(1, 3));
                    for (int k = 0; k < n; k++) host_write(4'($urandom), 8'($urandom));
                    bus_start(); t_addr(1'b0); t_ptr(8'($urandom));
                    col_en   = 1'($urandom_range(0, 1));
                    col_addr = 4'($urandom);
                    col_data = 8'($urandom);
                    t_wdata(8'($urandom));
                    t_wdata(8'($urandom));
                    t_end();
                end
                default: begin
                    bad = 7'($urandom);
                    if (bad == DEV) bad = 7'h51;
                    no_drive = 1'b1;
                    bus_start();
                    write_byte({bad, 1'($urandom)}, ack);
                    check("rnd_foreign_nack", 32'(ack), 32'd1);
                    write_byte(8'($urandom), ack);
                    bus_stop();
                    no_drive = 1'b0;
                    check("rnd_foreign_busy", 32'(busy), 32'd0);
                end
            endcase
        end

        check_regs();
        check("rx_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Synthesizable I2C target (slave) with a parametrised register bank, auto-incrementing register pointer, repeated-start support and a host-side access port. It sits beside the I2C controller in the CDC top and is the board-side counterpart of the controller. It replaces the fixed behavioural slave model used on the bench with RTL that can also ship as an on-chip peripheral. A host port lets fabric logic preload and observe the register bank while the bus is active.

## Interface
- DEV_ADDR, 7'h50, 7-bit target address.
- REG_DEPTH, 16, number of 8-bit registers; must be a power of two, minimum 2.
- REG_AW, $clog2(REG_DEPTH), pointer width (derived).
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i; minimum 2.

- clk  in  1  system clock (60 MHz nominal). Single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (pull-up). SCL is never driven.
- host_wr_en  in  1  host write strobe.
- host_addr  in  REG_AW  host register address, shared by read and write.
- host_wr_data  in  8  host write data.
- host_rd_data  out  8  regs[host_addr], combinational.
- rx_valid  out  1  one-cycle pulse per register written from I2C.
- rx_addr  out  REG_AW  register written; valid with rx_valid.
- rx_data  out  8  byte written; valid with rx_valid.
- busy  out  1  high from an addressed START or Sr until STOP or a NACK'd address.

## Operation
- scl_i and sda_i pass through SYNC_STAGES flops, then one edge-detect flop. Derived single-cycle events:
  - scl_rise, scl_fall
  - start: SDA falls while SCL is high
  - stop: SDA rises while SCL is high
- start and stop abort any state. start (including Sr) → ADDR. stop → IDLE.
- States:
  - IDLE: wait for start.
  - ADDR: shift 8 bits on scl_rise, MSB first. On match of addr[7:1] == DEV_ADDR, go to ADDR_ACK. On mismatch, go to IDLE with SDA untouched.
  - ADDR_ACK: sda_oe=1 from the scl_fall after bit 8 to the next scl_fall. Then R/W=0 → PTR; R/W=1 → RD_DATA.
  - PTR: shift 8 bits. pointer ← byte[REG_AW-1:0]. Then PTR_ACK, which ACKs like ADDR_ACK, then → WR_DATA.
  - WR_DATA: shift 8 bits. Then WR_ACK, which ACKs; on the scl_fall ending the ACK, write regs[pointer], pulse rx_valid, pointer++. Then → WR_DATA.
  - RD_DATA: on entry, snapshot regs[pointer] into the shift register. Drive sda_oe = ~bit on each scl_fall, MSB first. After 8 bits, release SDA → RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - ACK (0): pointer++, → RD_DATA (reload on the next scl_fall).
    - NACK (1): pointer++, → IDLE_WAIT, with SDA released until start/stop.
- Pointer arithmetic is modulo REG_DEPTH: REG_DEPTH-1 wraps to 0.
- The pointer persists across transactions and Sr. It resets to 0.
- Write-then-Sr-read returns data starting at the written pointer.
- A stop after PTR_ACK with no data bytes changes only the pointer.
- host_wr_en in the same cycle as an I2C register write to the same address: the I2C write wins, and the host write is dropped.
- Different addresses in the same cycle: both writes take effect.
- A host write to the register being shifted out does not alter the byte in flight; that byte was already snapshotted.

## Timing
- Input-to-event latency is SYNC_STAGES+1 clk cycles.
- SCL high and low phases must each be at least SYNC_STAGES+4 clk. At 60 MHz this covers 400 kHz Fast-mode with margin.
- sda_oe changes exactly one clk after the detected scl_fall. This gives master-read data hold ≥ SYNC_STAGES+2 clk after the real SCL fall.
- rx_valid asserts one clk after the scl_fall that ends the ACK bit; rx_addr and rx_data are stable in that cycle.
- Reset values:
  - sda_oe=0, rx_valid=0, rx_addr=0, rx_data=0, busy=0
  - state=IDLE, pointer=0
  - all registers 0
  - synchroniser flops = 1 (idle bus)
- Reset mid-transfer: the cycle after rst_n is sampled low, sda_oe=0. After release, the block ignores the bus until the next start.

## Structure
- Package i2c_tgt_pkg holds:
  - state enum: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IDLE_WAIT
  - localparams BIT_CNT_W=3, ACK=1'b0, NACK=1'b1
- Sub-module i2c_bus_sync contains the synchroniser and edge/start/stop detector, parametrised by SYNC_STAGES, with outputs scl_rise, scl_fall, start, stop, sda_s.
- Register bank: flop array inside the top module.

## Test plan
- Write 0xA0, ptr 0x0A, data 0x12 0x34, stop → ACK on all 4 bytes; regs[0xA]=0x12, regs[0xB]=0x34; two rx_valid pulses (0xA/0x12, 0xB/0x34); pointer=0xC.
- Host preloads regs[4..7] with DE AD BE EF. Then A0, ptr 04, Sr, A1, read 4 bytes with the last one NACK'd → bus returns DE AD BE EF; sda_oe=0 after the NACK; pointer=8; busy falls on stop.
- Address 0xA2 (7'h51) with a full write frame → sda_oe never asserts; no rx_valid; state returns to IDLE.
- ptr 0x0F, write 0x55 0x66 → regs[15]=0x55, regs[0]=0x66 (wrap). A following bare read returns regs[1].
- host_wr_en to address 3 in the same cycle as an I2C write of 0x77 to regs[3] → regs[3]=0x77.
- rst_n low during a read while bit 3 is driving low → sda_oe=0 on the next clk. After release, the block stays idle until a fresh start, then a write to ptr 0 succeeds.
